// File: rtl/lfsr_pkg.sv
// Shared types and helpers for the parameterised LFSR core.
package lfsr_pkg;

    typedef enum logic {
        LFSR_FIB = 1'b0,
        LFSR_GAL = 1'b1
    } lfsr_mode_e;

    typedef enum logic {
        LDR_RUN     = 1'b0,
        LDR_LOADING = 1'b1
    } ldr_state_e;

    // The prescaler never divides by less than one.
    localparam int unsigned MIN_DIV = 1;

    function automatic int unsigned calc_div(input int unsigned clock_hz,
                                             input int unsigned step_hz);
        int unsigned q;
        q = (step_hz == 0) ? clock_hz : clock_hz / step_hz;
        return (q < MIN_DIV) ? MIN_DIV : q;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lfsr_tick_gen.sv
// Prescaler: emits a one-cycle advance strobe every DIV enabled cycles.
module lfsr_tick_gen
    import lfsr_pkg::*;
#(
    parameter int unsigned DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic step_en,
    output logic strobe
);

    localparam int unsigned CNT_W = cnt_width(DIV);

    logic [CNT_W-1:0] count;
    logic             at_top;

    assign at_top = (count == CNT_W'(DIV - 1));
    assign strobe = step_en & at_top;

    // Counter only moves while enabled, so a paused run delays the strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (step_en) begin
            count <= at_top ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/param_lfsr_core.sv
// Parameterised Fibonacci/Galois LFSR with beat-wise tap and seed loading.
// Optional lockup reseed enabled by defining LFSR_LOCKUP_RECOVERY_EN.
module param_lfsr_core
    import lfsr_pkg::*;
#(
    parameter int unsigned       WIDTH        = 16,
    parameter int unsigned       LOAD_W       = 4,
    parameter int unsigned       CLOCK_HZ     = 12500,
    parameter int unsigned       STEP_HZ      = 10,
    parameter logic [WIDTH-1:0]  DEFAULT_TAPS = 16'hB400,
    parameter logic [WIDTH-1:0]  DEFAULT_SEED = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              taps_load,
    input  logic              seed_load,
    input  logic [LOAD_W-1:0] load_data,
    input  logic              mode,
    input  logic              step_en,
    output logic [WIDTH-1:0]  state,
    output logic              tick,
    output logic              lockup
);

    localparam int unsigned DIV    = calc_div(CLOCK_HZ, STEP_HZ);
    localparam int unsigned BEATS  = WIDTH / LOAD_W;
    localparam int unsigned BEAT_W = cnt_width(BEATS);

    logic              strobe;
    ldr_state_e        ldr_state;
    ldr_state_e        ldr_next;
    logic [BEAT_W-1:0] beat_cnt;
    logic [BEAT_W-1:0] beat_next;
    logic              drop_c;
    logic              advance_c;
    logic [WIDTH-1:0]  taps_r;
    logic [WIDTH-1:0]  adv_val_c;
    logic [WIDTH-1:0]  state_d;
    lfsr_mode_e        mode_e;

    lfsr_tick_gen #(.DIV(DIV)) u_tick_gen (
        .clk     (clk),
        .reset   (reset),
        .step_en (step_en),
        .strobe  (strobe)
    );

    // Tap-loader FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            ldr_state <= LDR_RUN;
            beat_cnt  <= '0;
        end else begin
            ldr_state <= ldr_next;
            beat_cnt  <= beat_next;
        end
    end

    // Tap-loader next state; a paused load simply holds.
    always_comb begin
        ldr_next  = ldr_state;
        beat_next = beat_cnt;
        case (ldr_state)
            LDR_RUN: begin
                if (taps_load) begin
                    ldr_next  = LDR_LOADING;
                    beat_next = BEAT_W'(1);
                end
            end
            LDR_LOADING: begin
                if (taps_load) begin
                    if (beat_cnt == BEAT_W'(BEATS - 1)) begin
                        ldr_next  = LDR_RUN;
                        beat_next = '0;
                    end else begin
                        beat_next = beat_cnt + BEAT_W'(1);
                    end
                end
            end
            default: begin
                ldr_next  = LDR_RUN;
                beat_next = '0;
            end
        endcase
    end

    // Advance is suppressed whenever either register is being rewritten.
    always_comb begin
        drop_c    = 1'b0;
        advance_c = 1'b0;
        drop_c    = (ldr_state == LDR_LOADING) | taps_load | seed_load;
        advance_c = strobe & ~drop_c;
    end

    assign mode_e = lfsr_mode_e'(mode);

    always_comb begin
        adv_val_c = state;
        state_d   = state;
        if (mode_e == LFSR_GAL) begin
            adv_val_c = {state[WIDTH-2:0], 1'b0} ^ (state[WIDTH-1] ? taps_r : '0);
        end else begin
            adv_val_c = {state[WIDTH-2:0], ^(state & taps_r)};
        end
`ifdef LFSR_LOCKUP_RECOVERY_EN
        if (state == '0) begin
            adv_val_c = DEFAULT_SEED;
        end
`endif
        if (seed_load) begin
            state_d = {state[WIDTH-LOAD_W-1:0], load_data};
        end else if (advance_c) begin
            state_d = adv_val_c;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= DEFAULT_SEED;
            taps_r <= DEFAULT_TAPS;
            tick   <= 1'b0;
            lockup <= 1'b0;
        end else begin
            if (taps_load) begin
                taps_r <= {taps_r[WIDTH-LOAD_W-1:0], load_data};
            end
            state  <= state_d;
            tick   <= advance_c;
            lockup <= (state_d == '0);
        end
    end

endmodule

// File: tb/tb_param_lfsr_core.sv
// Self-checking bench for param_lfsr_core: directed scenarios plus random
// stimulus against a behavioural model, on a DIV=1 and a DIV=5 instance.
module tb_param_lfsr_core;

`ifdef LFSR_LOCKUP_RECOVERY_EN
    localparam bit RECOVERY = 1'b1;
`else
    localparam bit RECOVERY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       taps_load;
    logic       seed_load;
    logic [3:0] load_data;
    logic       mode;
    logic       step_en;
    logic [7:0] st0, st1;
    logic       tick0, tick1, lk0, lk1;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int st;
        int taps;
        int cnt;
        bit loading;
        int beats;
        bit tick;
        bit lockup;
    } mdl_t;

    mdl_t m0, m1;

    always #5 clk = ~clk;

    param_lfsr_core #(
        .WIDTH(8), .LOAD_W(4), .CLOCK_HZ(1), .STEP_HZ(1),
        .DEFAULT_TAPS(8'hB8), .DEFAULT_SEED(8'h01)
    ) dut0 (
        .clk(clk), .reset(reset), .taps_load(taps_load), .seed_load(seed_load),
        .load_data(load_data), .mode(mode), .step_en(step_en),
        .state(st0), .tick(tick0), .lockup(lk0)
    );

    param_lfsr_core #(
        .WIDTH(8), .LOAD_W(4), .CLOCK_HZ(10), .STEP_HZ(2),
        .DEFAULT_TAPS(8'hB8), .DEFAULT_SEED(8'h01)
    ) dut1 (
        .clk(clk), .reset(reset), .taps_load(taps_load), .seed_load(seed_load),
        .load_data(load_data), .mode(mode), .step_en(step_en),
        .state(st1), .tick(tick1), .lockup(lk1)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    endtask

    // One-step reference: next visible state from current inputs, using the
    // two-beat load of an 8-bit register in 4-bit chunks.
    function automatic mdl_t mdl_next(input mdl_t m, input int div);
        mdl_t n;
        bit   strobe, take;
        n = m;
        if (reset) begin
            n.st = 1; n.taps = 'hB8; n.cnt = 0; n.loading = 0;
            n.beats = 0; n.tick = 0; n.lockup = 0;
            return n;
        end
        strobe = step_en && (m.cnt == div - 1);
        if (step_en) n.cnt = (m.cnt + 1) % div;
        take = strobe && !(m.loading || taps_load || seed_load);
        if (seed_load) begin
            n.st = (m.st * 16 + int'(load_data)) % 256;
        end else if (take) begin
            if (m.st == 0 && RECOVERY)
                n.st = 1;
            else if (mode == 1'b0)
                n.st = (m.st * 2) % 256 + ($countones(m.st & m.taps) % 2);
            else
                n.st = ((m.st * 2) % 256) ^ ((m.st >= 128) ? m.taps : 0);
        end
        if (taps_load) begin
            n.taps = (m.taps * 16 + int'(load_data)) % 256;
            if (!m.loading) begin
                n.loading = 1; n.beats = 1;
            end else if (m.beats == 1) begin
                n.loading = 0; n.beats = 0;
            end else begin
                n.beats = m.beats + 1;
            end
        end
        n.tick   = take;
        n.lockup = (n.st == 0);
        return n;
    endfunction

    task automatic step_cycle();
        @(posedge clk);
        m0 = mdl_next(m0, 1);
        m1 = mdl_next(m1, 5);
        @(negedge clk);
        check_eq("d0_state", int'(st0), m0.st);
        check_eq("d0_tick", int'(tick0), int'(m0.tick));
        check_eq("d0_lockup", int'(lk0), int'(m0.lockup));
        check_eq("d1_state", int'(st1), m1.st);
        check_eq("d1_tick", int'(tick1), int'(m1.tick));
        check_eq("d1_lockup", int'(lk1), int'(m1.lockup));
    endtask

    task automatic idle_inputs();
        reset = 0; taps_load = 0; seed_load = 0; load_data = 0; mode = 0; step_en = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        step_cycle();
        reset = 0;
    endtask

    task automatic seed_beat(input logic [3:0] d);
        seed_load = 1; load_data = d;
        step_cycle();
        seed_load = 0;
    endtask

    initial begin
        int n;
        int s_before;
        idle_inputs();

        // Reset values
        step_en = 1; taps_load = 1;
        do_reset();
        taps_load = 0;
        check_eq("rst_state", int'(st0), 'h01);
        check_eq("rst_tick", int'(tick0), 0);
        check_eq("rst_lockup", int'(lk0), 0);

        // Fibonacci sequence and period
        mode = 0; step_en = 1;
        step_cycle(); check_eq("fib_1", int'(st0), 'h02);
        step_cycle(); check_eq("fib_2", int'(st0), 'h04);
        step_cycle(); check_eq("fib_3", int'(st0), 'h08);
        step_cycle(); check_eq("fib_4", int'(st0), 'h11);
        check_eq("fib_tick", int'(tick0), 1);
        n = 4;
        while (st0 != 8'h01 && n < 300) begin
            step_cycle();
            n++;
        end
        check_eq("fib_period", n, 255);

        // Galois
        step_en = 0;
        do_reset();
        seed_beat(4'h8);
        seed_beat(4'h0);
        check_eq("gal_seed", int'(st0), 'h80);
        mode = 1; step_en = 1;
        step_cycle();
        check_eq("gal_adv", int'(st0), 'hB8);
        step_en = 0; mode = 0;

        // Prescaler on the DIV=5 instance
        do_reset();
        step_en = 1;
        n = 0;
        do begin step_cycle(); n++; end while (!tick1 && n < 20);
        check_eq("presc_first", n, 5);
        n = 0;
        do begin step_cycle(); n++; end while (!tick1 && n < 20);
        check_eq("presc_gap", n, 5);
        step_cycle(); n = 1;
        step_en = 0;
        repeat (3) begin step_cycle(); n++; end
        step_en = 1;
        do begin step_cycle(); n++; end while (!tick1 && n < 30);
        check_eq("presc_pause_gap", n, 8);

        // Tap load with a pause between beats
        step_en = 0;
        do_reset();
        s_before = int'(st0);
        mode = 0; step_en = 1; taps_load = 1; load_data = 4'hA;
        step_cycle();
        taps_load = 0;
        repeat (4) begin
            step_cycle();
            check_eq("load_hold_state", int'(st0), s_before);
            check_eq("load_hold_tick", int'(tick0), 0);
        end
        taps_load = 1; load_data = 4'h6;
        step_cycle();
        check_eq("load_done_state", int'(st0), s_before);
        taps_load = 0;
        step_cycle();
        check_eq("load_resume_state", int'(st0), 'h02);
        check_eq("load_resume_tick", int'(tick0), 1);
        step_en = 0;
        seed_beat(4'h8);
        seed_beat(4'h0);
        mode = 1; step_en = 1;
        step_cycle();
        check_eq("load_taps_A6", int'(st0), 'hA6);
        step_en = 0; mode = 0;

        // Lockup
        seed_beat(4'h0);
        seed_beat(4'h0);
        check_eq("lock_state", int'(st0), 'h00);
        check_eq("lock_flag", int'(lk0), 1);
        step_en = 1;
        if (RECOVERY) begin
            step_cycle();
            check_eq("lock_reseed", int'(st0), 'h01);
            check_eq("lock_clear", int'(lk0), 0);
            check_eq("lock_tick", int'(tick0), 1);
        end else begin
            repeat (10) step_cycle();
            check_eq("lock_stays", int'(st0), 'h00);
            check_eq("lock_held", int'(lk0), 1);
        end
        step_en = 0;

        // Reset during a load and while stepping
        do_reset();
        step_en = 1; taps_load = 1; load_data = 4'hA;
        step_cycle();
        load_data = 4'h5; reset = 1;
        step_cycle();
        reset = 0; taps_load = 0;
        check_eq("midrst_state", int'(st0), 'h01);
        check_eq("midrst_tick", int'(tick0), 0);
        step_cycle();
        check_eq("midrst_resume", int'(st0), 'h02);
        step_en = 0;
        seed_beat(4'h8);
        seed_beat(4'h0);
        mode = 1; step_en = 1;
        step_cycle();
        check_eq("midrst_taps_B8", int'(st0), 'hB8);

        // Random stimulus
        for (int i = 0; i < 2000; i++) begin
            reset     = ($urandom % 80) == 0;
            taps_load = ($urandom % 6) == 0;
            seed_load = ($urandom % 7) == 0;
            load_data = 4'($urandom);
            if (($urandom % 16) == 0) mode = ~mode;
            step_en   = ($urandom % 4) != 0;
            step_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
